generador_ventana_5x5: RTL and testbench
========================================

GENERADOR_VENTANA_5X5 -- requirements
Module: generador_ventana_5x5

Interface
REQ-001 SHALL have parameter BITS_PIXEL, default 8, meaning the unsigned pixel width.
REQ-002 SHALL have parameter ANCHO_IMAGEN, default 640, meaning pixels per line (range 5..4096).
REQ-003 SHALL have parameter ALTO_IMAGEN, default 480, meaning lines per frame (range 5..4096).
REQ-004 SHALL have port: clk  input  1  single clock, rising edge.
REQ-005 SHALL have port: reset_n  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port: inicio_cuadro  input  1  start-of-frame, qualified by pixel_valid.
REQ-007 SHALL have port: pixel_in  input  BITS_PIXEL  raster-order pixel.
REQ-008 SHALL have port: pixel_valid  input  1  pixel_in accepted this cycle.
REQ-009 SHALL have port: ventana  output  25*BITS_PIXEL  packed 5x5 window; slice k-1 holds window element k.
REQ-010 SHALL have port: ventana_valid  output  1  ventana holds a complete in-image window.
REQ-011 SHALL have port: fin_cuadro  output  1  one-cycle pulse after the frame's last pixel.

Function
REQ-012 SHALL number window elements k=1..25 as row*5+col+1; row 0 = oldest line, col 0 = oldest column, so element 25 is the newest pixel.
REQ-013 SHALL accept one pixel per cycle when pixel_valid=1, with no backpressure; pixel_valid=0 cycles are gaps that SHALL NOT advance any state.
REQ-014 SHALL keep a column counter 0..ANCHO_IMAGEN-1 and a row counter 0..ALTO_IMAGEN-1; the column wraps to 0 after ANCHO_IMAGEN-1 and increments the row.
REQ-015 SHALL store the last four lines in four line buffers of ANCHO_IMAGEN entries each; each buffer is read and written at the current column address on every accepted pixel.
REQ-016 SHALL shift a 5x5 register array left by one column per accepted pixel; the new column is formed from the four line-buffer outputs plus pixel_in.
REQ-017 SHALL update ventana and ventana_valid one cycle after the accepting edge (latency 1).
REQ-018 SHALL assert ventana_valid for one cycle per accepted pixel whose row>=4 and col>=4; the frame yields (ANCHO_IMAGEN-4)*(ALTO_IMAGEN-4) windows and no zero padding.
REQ-019 SHALL hold ventana_valid low during gaps; ventana keeps its last value.
REQ-020 SHALL use an FSM with three states. ESPERA: ignore pixels until pixel_valid&inicio_cuadro. ACTIVO: stream. COMPLETO: entered after pixel (ALTO_IMAGEN-1, ANCHO_IMAGEN-1) is accepted; fin_cuadro pulses on entry; return to ESPERA next cycle.
REQ-021 SHALL treat the pixel carrying inicio_cuadro as pixel (0,0) of a new frame, with counters forced to 0, in any state, including mid-frame; a partial frame is abandoned without fin_cuadro.
REQ-022 SHALL ignore pixels accepted in ESPERA or COMPLETO unless inicio_cuadro is set.
REQ-023 SHALL NOT clear line-buffer contents on frame start; stale data is masked by the REQ-018 row/col qualification.

Reset
REQ-024 SHALL, on reset_n=0, asynchronously set: state=ESPERA, counters=0, ventana_valid=0, fin_cuadro=0, ventana=0.
REQ-025 SHALL leave line-buffer RAM contents undefined by reset.
REQ-026 SHALL treat reset mid-frame as abandoning the frame; streaming resumes only on the next inicio_cuadro.

Structure
REQ-027 SHALL place the window size (5), element count (25) and FSM state encoding in shared package ventana_pkg.
REQ-028 SHALL implement the line buffer as a single sub-module buffer_linea (parameters BITS_PIXEL, ANCHO_IMAGEN; single-port read-during-write returning old data), instantiated four times in a chain.

Verification
Use ANCHO_IMAGEN=8, ALTO_IMAGEN=6 and pixel value row*16+col throughout.
REQ-029 SHALL test a contiguous frame: first ventana_valid occurs one cycle after pixel (4,4), with element1=0x00, element13=0x22 and element25=0x44; exactly 8 windows follow, then one fin_cuadro pulse.
REQ-030 SHALL test random pixel_valid gaps: the window sequence is identical to REQ-029 and ventana_valid never asserts during a gap.
REQ-031 SHALL test inicio_cuadro asserted at pixel (3,2) mid-frame and then a full frame: no fin_cuadro for the partial frame, and the full frame yields exactly 8 correct windows.
REQ-032 SHALL test pixels streamed before any inicio_cuadro: no ventana_valid and no fin_cuadro are produced.
REQ-033 SHALL test reset_n pulsed low at pixel (4,6): outputs are 0 immediately, and the next full frame reproduces REQ-029.
REQ-034 SHALL test two back-to-back frames with no gap: second-frame window 1 equals 0x00..0x44 with no first-frame data, and each frame produces one fin_cuadro.

Source files
------------

// File: rtl/ventana_pkg.sv
// Shared constants and FSM encoding for the 5x5 window generator.
package ventana_pkg;
  localparam int TAM_VENTANA   = 5;
  localparam int NUM_ELEMENTOS = TAM_VENTANA * TAM_VENTANA;
  localparam int NUM_LINEAS    = TAM_VENTANA - 1;

  typedef enum logic [1:0] {
    ESPERA   = 2'd0,
    ACTIVO   = 2'd1,
    COMPLETO = 2'd2
  } estado_t;
endpackage

// File: rtl/buffer_linea.sv
// One image line of storage; asynchronous read, so a read-during-write at the
// same address returns the value stored one line earlier.
module buffer_linea #(
  parameter int BITS_PIXEL   = 8,
  parameter int ANCHO_IMAGEN = 640
) (
  input  logic                            clk,
  input  logic                            we_i,
  input  logic [$clog2(ANCHO_IMAGEN)-1:0] dir_i,
  input  logic [BITS_PIXEL-1:0]           dato_i,
  output logic [BITS_PIXEL-1:0]           dato_o
);
  logic [BITS_PIXEL-1:0] mem_q [ANCHO_IMAGEN];

  always_ff @(posedge clk)
    if (we_i) mem_q[dir_i] <= dato_i;

  assign dato_o = mem_q[dir_i];
endmodule

// File: rtl/generador_ventana_5x5.sv
// Streams raster pixels through four chained line buffers and a 5x5 shift
// window; flags windows fully inside the image and pulses at end of frame.
module generador_ventana_5x5
  import ventana_pkg::*;
#(
  parameter int BITS_PIXEL   = 8,
  parameter int ANCHO_IMAGEN = 640,
  parameter int ALTO_IMAGEN  = 480
) (
  input  logic                                clk,
  input  logic                                reset_n,
  input  logic                                inicio_cuadro,
  input  logic [BITS_PIXEL-1:0]               pixel_in,
  input  logic                                pixel_valid,
  output logic [NUM_ELEMENTOS*BITS_PIXEL-1:0] ventana,
  output logic                                ventana_valid,
  output logic                                fin_cuadro
);
  localparam int CW = $clog2(ANCHO_IMAGEN);
  localparam int FW = $clog2(ALTO_IMAGEN);
  localparam logic [CW-1:0] COL_MAX  = CW'(ANCHO_IMAGEN - 1);
  localparam logic [FW-1:0] FILA_MAX = FW'(ALTO_IMAGEN - 1);

  estado_t         estado_q, estado_d;
  logic [CW-1:0]   col_q, col_d, col_px;
  logic [FW-1:0]   fila_q, fila_d, fila_px;
  logic            vld_q, vld_d;
  logic            acepta, fin_linea, ultimo;

  logic [TAM_VENTANA-1:0][TAM_VENTANA-1:0][BITS_PIXEL-1:0] win_q, win_d;
  // linea[0] is the live pixel, linea[i] the same column i lines earlier
  logic [NUM_LINEAS:0][BITS_PIXEL-1:0] linea;

  assign acepta    = pixel_valid & (inicio_cuadro | (estado_q == ACTIVO));
  assign col_px    = inicio_cuadro ? '0 : col_q;
  assign fila_px   = inicio_cuadro ? '0 : fila_q;
  assign fin_linea = (col_px == COL_MAX);
  assign ultimo    = acepta & fin_linea & (fila_px == FILA_MAX);

  assign linea[0] = pixel_in;

  for (genvar i = 0; i < NUM_LINEAS; i++) begin : g_lineas
    buffer_linea #(
      .BITS_PIXEL  (BITS_PIXEL),
      .ANCHO_IMAGEN(ANCHO_IMAGEN)
    ) u_buf (
      .clk   (clk),
      .we_i  (acepta),
      .dir_i (col_px),
      .dato_i(linea[i]),
      .dato_o(linea[i+1])
    );
  end

  always_comb begin
    estado_d   = estado_q;
    col_d      = col_q;
    fila_d     = fila_q;
    fin_cuadro = 1'b0;
    vld_d      = acepta & (fila_px >= FW'(NUM_LINEAS)) & (col_px >= CW'(NUM_LINEAS));

    if (acepta) begin
      if (fin_linea) begin
        col_d  = '0;
        fila_d = ultimo ? '0 : fila_px + 1'b1;
      end else begin
        col_d  = col_px + 1'b1;
        fila_d = fila_px;
      end
    end

    case (estado_q)
      ESPERA:   if (acepta) estado_d = ACTIVO;
      ACTIVO:   if (ultimo) estado_d = COMPLETO;
      COMPLETO: begin
        fin_cuadro = 1'b1;
        estado_d   = acepta ? ACTIVO : ESPERA;
      end
      default:  estado_d = ESPERA;
    endcase
  end

  // Row 0 of the window is the oldest line, so it takes the deepest buffer.
  always_comb begin
    win_d = win_q;
    if (acepta) begin
      for (int r = 0; r < TAM_VENTANA; r++) begin
        for (int c = 0; c < TAM_VENTANA - 1; c++)
          win_d[r][c] = win_q[r][c+1];
        win_d[r][TAM_VENTANA-1] = linea[NUM_LINEAS-r];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      estado_q <= ESPERA;
      col_q    <= '0;
      fila_q   <= '0;
      vld_q    <= 1'b0;
      win_q    <= '0;
    end else begin
      estado_q <= estado_d;
      col_q    <= col_d;
      fila_q   <= fila_d;
      vld_q    <= vld_d;
      win_q    <= win_d;
    end
  end

  assign ventana       = win_q;
  assign ventana_valid = vld_q;
endmodule

// File: tb/tb_generador_ventana_5x5.sv
// Bench for generador_ventana_5x5 on an 8x6 image with pixel = row*16+col,
// random gaps and junk pixels, checked against windows computed from coordinates.
module tb_generador_ventana_5x5;
  localparam int BP = 8;
  localparam int AN = 8;
  localparam int AL = 6;
  localparam int W  = 25 * BP;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          inicio_cuadro;
  logic [BP-1:0] pixel_in;
  logic          pixel_valid;
  logic [W-1:0]  ventana;
  logic          ventana_valid;
  logic          fin_cuadro;

  int           checks = 0;
  int           failures = 0;
  int           nwin, nfin;
  logic [W-1:0] ult_win;
  bit           ult_ok;

  generador_ventana_5x5 #(
    .BITS_PIXEL  (BP),
    .ANCHO_IMAGEN(AN),
    .ALTO_IMAGEN (AL)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .inicio_cuadro(inicio_cuadro),
    .pixel_in     (pixel_in),
    .pixel_valid  (pixel_valid),
    .ventana      (ventana),
    .ventana_valid(ventana_valid),
    .fin_cuadro   (fin_cuadro)
  );

  always #5 clk = ~clk;

  // Element k (row i, col j) of the window ending at (r,c) is image pixel (r-4+i, c-4+j).
  function automatic logic [W-1:0] win_esp(input int r, input int c);
    logic [W-1:0] w;
    w = '0;
    for (int i = 0; i < 5; i++)
      for (int j = 0; j < 5; j++)
        w[(i*5+j)*BP +: BP] = BP'((r - 4 + i) * 16 + (c - 4 + j));
    return w;
  endfunction

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] esp);
    checks++;
    assert (obs === esp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, esp);
    end
  endtask

  // One clock: drive, take the edge, check outputs produced by that edge.
  task automatic paso(input bit v, input bit sof, input logic [BP-1:0] px, input bit acc,
                      input bit exp_v, input logic [W-1:0] exp_w, input bit exp_fin,
                      input string tag);
    pixel_valid   = v;
    inicio_cuadro = sof;
    pixel_in      = px;
    @(posedge clk);
    #1;
    nwin += int'(ventana_valid);
    nfin += int'(fin_cuadro);
    chk({tag, " valid"}, W'(ventana_valid), W'(exp_v));
    chk({tag, " fin"}, W'(fin_cuadro), W'(exp_fin));
    if (exp_v) begin
      chk({tag, " win"}, ventana, exp_w);
      ult_win = exp_w;
      ult_ok  = 1'b1;
    end else if (!acc) begin
      if (ult_ok) chk({tag, " hold"}, ventana, ult_win);
    end else begin
      ult_ok = 1'b0;
    end
  endtask

  task automatic pixel(input int r, input int c, input bit sof, input string nom);
    paso(1'b1, sof, BP'(r * 16 + c), 1'b1, (r >= 4 && c >= 4), win_esp(r, c),
         (r == AL - 1 && c == AN - 1), $sformatf("%s r%0d c%0d", nom, r, c));
  endtask

  task automatic hueco(input string nom);
    paso(1'b0, 1'b0, BP'($urandom), 1'b0, 1'b0, '0, 1'b0, {nom, " gap"});
  endtask

  task automatic basura(input int n, input string nom);
    for (int i = 0; i < n; i++)
      paso(1'b1, 1'b0, BP'($urandom), 1'b0, 1'b0, '0, 1'b0, {nom, " junk"});
  endtask

  task automatic cuadro(input int pct_gap, input string nom);
    nwin = 0;
    nfin = 0;
    for (int r = 0; r < AL; r++)
      for (int c = 0; c < AN; c++) begin
        for (int g = 0; g < 4 && $urandom_range(99) < pct_gap; g++) hueco(nom);
        pixel(r, c, (r == 0 && c == 0), nom);
        if (r == 4 && c == 4) begin
          chk({nom, " e1"},  W'(ventana[0 +: BP]),      W'(8'h00));
          chk({nom, " e13"}, W'(ventana[12*BP +: BP]), W'(8'h22));
          chk({nom, " e25"}, W'(ventana[24*BP +: BP]), W'(8'h44));
        end
      end
    chk({nom, " nwin"}, W'(nwin), W'((AN - 4) * (AL - 4)));
    chk({nom, " nfin"}, W'(nfin), W'(1));
  endtask

  task automatic parcial(input int n, input string nom);
    for (int idx = 0; idx < n; idx++) pixel(idx / AN, idx % AN, idx == 0, nom);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    reset_n       = 1'b1;
    pixel_valid   = 1'b0;
    inicio_cuadro = 1'b0;
    pixel_in      = '0;
    #2 reset_n = 1'b0;
    #1;
    chk("rst ventana", ventana, '0);
    chk("rst valid", W'(ventana_valid), W'(0));
    chk("rst fin", W'(fin_cuadro), W'(0));
    @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    ult_win = '0;
    ult_ok  = 1'b1;
    nwin    = 0;
    nfin    = 0;

    // Pixels before any frame start are ignored
    basura(20, "req032");
    chk("req032 nwin", W'(nwin), W'(0));
    chk("req032 nfin", W'(nfin), W'(0));

    cuadro(0, "req029");
    for (int i = 0; i < 3; i++) hueco("req029 idle");

    cuadro(30, "req030");
    for (int i = 0; i < 2; i++) hueco("req030 idle");

    // Frame restarted where (3,2) would have been
    nwin = 0;
    nfin = 0;
    parcial(26, "req031p");
    chk("req031p nfin", W'(nfin), W'(0));
    cuadro(0, "req031");
    hueco("req031 idle");

    // Reset arrives where (4,6) would have been
    nwin = 0;
    nfin = 0;
    parcial(38, "req033p");
    chk("req033p nwin", W'(nwin), W'(2));
    reset_n = 1'b0;
    pixel_valid = 1'b0;
    #1;
    chk("req033 rst ventana", ventana, '0);
    chk("req033 rst valid", W'(ventana_valid), W'(0));
    chk("req033 rst fin", W'(fin_cuadro), W'(0));
    @(posedge clk);
    #1 reset_n = 1'b1;
    ult_win = '0;
    ult_ok  = 1'b1;
    nwin    = 0;
    nfin    = 0;
    basura(6, "req033");
    chk("req033 junk nwin", W'(nwin), W'(0));
    cuadro(20, "req033");

    cuadro(0, "req034a");
    cuadro(0, "req034b");
    for (int i = 0; i < 3; i++) hueco("req034 idle");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
